// File: rtl/d24_arbiter_if.sv
// rtl/d24_arbiter_if.sv - request/grant bundle between requesters and the d24 arbiter
interface d24_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] hold_cnt;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  hold_cnt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output hold_cnt
    );
endinterface

// File: rtl/d24_arbiter.sv
// rtl/d24_arbiter.sv - 4-way round-robin arbiter with bounded hold time and decoded grant
module d24_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    d24_arbiter_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_vld;
    logic [7:0] r_hold_cnt;

    logic [3:0] w_mask;
    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_win;
    logic       w_own_req;

    function automatic logic [3:0] f_decode(input logic [1:0] idx);
        f_decode = 4'(4'b0001 << idx);
    endfunction

    // The current grantee is masked out so a timeout only rotates to someone else.
    always_comb begin
        w_mask    = r_gnt_vld ? f_decode(r_gnt_idx) : 4'b0000;
        w_cand    = bus.req & ~w_mask;
        w_own_req = bus.req[r_gnt_idx];
        w_found   = 1'b0;
        w_win     = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (w_cand[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd0;
            r_gnt      <= 4'b0000;
            r_gnt_idx  <= 2'd0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state    <= BUSY;
                        r_gnt      <= f_decode(w_win);
                        r_gnt_idx  <= w_win;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= 8'd0;
                        r_ptr      <= w_win + 2'd1;
                    end
                end
                BUSY: begin
                    // Release is tested first so it wins over a coincident timeout.
                    if (!w_own_req) begin
                        if (w_found) begin
                            r_gnt      <= f_decode(w_win);
                            r_gnt_idx  <= w_win;
                            r_hold_cnt <= 8'd0;
                            r_ptr      <= w_win + 2'd1;
                        end else begin
                            r_state    <= IDLE;
                            r_gnt      <= 4'b0000;
                            r_gnt_vld  <= 1'b0;
                            r_hold_cnt <= 8'd0;
                        end
                    end else if (r_hold_cnt >= HOLD_LAST) begin
                        if (w_found) begin
                            r_gnt      <= f_decode(w_win);
                            r_gnt_idx  <= w_win;
                            r_hold_cnt <= 8'd0;
                            r_ptr      <= w_win + 2'd1;
                        end else begin
                            r_hold_cnt <= 8'd0;
                            r_ptr      <= r_gnt_idx + 2'd1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_gnt     <= 4'b0000;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.gnt_idx  = r_gnt_idx;
    assign bus.gnt_vld  = r_gnt_vld;
    assign bus.hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_d24_arbiter.sv
// tb/tb_d24_arbiter.sv - directed vector bench for d24_arbiter
module tb_d24_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    d24_arbiter_if bus ();

    d24_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic [7:0] hold;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, k, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int k, input logic [3:0] g,
                           input logic [1:0] idx, input logic v, input logic [7:0] h);
        chk({nm, ".gnt"}, k, 8'(bus.gnt), 8'(g));
        chk({nm, ".vld"}, k, 8'(bus.gnt_vld), 8'(v));
        chk({nm, ".hold"}, k, bus.hold_cnt, h);
        if (v) chk({nm, ".idx"}, k, 8'(bus.gnt_idx), 8'(idx));
        chk({nm, ".onehot"}, k, 8'($onehot0(bus.gnt) && (bus.gnt_vld || bus.gnt == 4'b0000)), 8'd1);
    endtask

    task automatic step(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        bus.req = 4'b0000;

        vecs[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'd0};
        vecs[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'd1};
        vecs[2]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'd0};
        vecs[3]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'd0};
        vecs[4]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'd1};
        vecs[5]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 8'd0};
        vecs[6]  = '{4'b1001, 4'b0001, 2'd0, 1'b1, 8'd1};
        vecs[7]  = '{4'b1000, 4'b1000, 2'd3, 1'b1, 8'd0};
        vecs[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 8'd1};
        vecs[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'd0};
        vecs[10] = '{4'b1001, 4'b0001, 2'd0, 1'b1, 8'd0};
        vecs[11] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 8'd0};

        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 4'b0000, 2'd0, 1'b0, 8'd0);
        chk("reset.idx", 0, 8'(bus.gnt_idx), 8'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            step(vecs[k].req);
            chk_out("vec", k, vecs[k].gnt, vecs[k].idx, vecs[k].vld, vecs[k].hold);
        end

        // Lone requester 1 (ptr=1): holds through timeouts, then releases exactly at hold 7.
        for (int c = 0; c < 24; c++) begin
            step(4'b0010);
            chk_out("lone", c, 4'b0010, 2'd1, 1'b1, 8'(c % 8));
        end
        step(4'b0000);
        chk_out("rel_at_tmo", 0, 4'b0000, 2'd0, 1'b0, 8'd0);

        // Async reset mid-grant, then restart from ptr=0.
        step(4'b0010);
        chk_out("pre_rst", 0, 4'b0010, 2'd1, 1'b1, 8'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 4'b0000, 2'd0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0110);
        chk_out("post_rst", 0, 4'b0010, 2'd1, 1'b1, 8'd0);
        step(4'b0000);
        chk_out("post_rst", 1, 4'b0000, 2'd0, 1'b0, 8'd0);

        #2;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        chk_out("rst2", 0, 4'b0000, 2'd0, 1'b0, 8'd0);

        // Full contention from ptr=0: rotation 0,1,2,3,0 with 8-cycle grants.
        for (int c = 0; c < 33; c++) begin
            step(4'b1111);
            chk_out("full", c, 4'(4'b0001 << ((c / 8) % 4)), 2'((c / 8) % 4), 1'b1, 8'(c % 8));
        end
        step(4'b0000);
        chk_out("full_end", 0, 4'b0000, 2'd0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
